ebr_port_arbiter: RTL and testbench
===================================

EBR_PORT_ARBITER -- requirements
Module: ebr_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13, the word-address width of the single-port 8K EBR.
REQ-002 Parameter DATA_W, default 9, the EBR data width.
REQ-003 Parameter OUTREG, default 0, where 1 means the EBR output register is enabled and adds 1 cycle of read latency.
REQ-004 Parameter CLEAR_ON_RESET, default 0, where 1 means the block zero-fills the EBR after reset release.
REQ-005 CLK  in  1  sole clock; all state changes on the rising edge.
REQ-006 RST  in  1  reset; asynchronous and active-high.
REQ-007 CLR  in  1  single-cycle pulse that starts a zero-fill of the EBR.
REQ-008 BUSY  out  1  high while a zero-fill is in progress.
REQ-009 REQ_A, REQ_B  in  1 each  requester command valid.
REQ-010 WE_A, WE_B  in  1 each  command is a write (1) or a read (0).
REQ-011 ADDR_A, ADDR_B  in  ADDR_W each  command address.
REQ-012 WDATA_A, WDATA_B  in  DATA_W each  write data.
REQ-013 GNT_A, GNT_B  out  1 each  combinational grant; REQ_x and GNT_x high at a rising edge means the command is accepted.
REQ-014 RVALID_A, RVALID_B  out  1 each  single-cycle read-return strobe.
REQ-015 RDATA_A, RDATA_B  out  DATA_W each  read data; holds its value between strobes.
REQ-016 RAM_CE, RAM_OCE, RAM_WE  out  1 each  EBR controls.
REQ-017 RAM_AD  out  ADDR_W  EBR address.
REQ-018 RAM_DI  out  DATA_W  EBR write data.
REQ-019 RAM_DO  in  DATA_W  EBR read data.

Function
REQ-020 The block SHALL have states CLEAR and SERVE; SERVE→CLEAR on a CLR pulse, or on reset release when CLEAR_ON_RESET=1; CLEAR→SERVE after the write to the last address.
REQ-021 In CLEAR, the block SHALL write zeros to addresses 0 through 2^ADDR_W-1, one address per cycle in ascending order; BUSY=1, GNT_A=GNT_B=0, and CLR is ignored.
REQ-022 In SERVE, at most one grant SHALL be high per cycle.
REQ-023 In SERVE, a lone request SHALL be granted in the same cycle.
REQ-024 With both REQ high, the grant SHALL go to the requester not granted last; the last-granted pointer updates only on an accepted command.
REQ-025 An accepted command in cycle N SHALL be presented registered on RAM_CE=1, RAM_WE, RAM_AD and RAM_DI during cycle N+1; with no command, RAM_CE=0.
REQ-026 RAM_OCE SHALL be 1 whenever RST is low.
REQ-027 A read accepted in cycle N SHALL assert RVALID_x for exactly one cycle at N+3+OUTREG, with RDATA_x registered from RAM_DO.
REQ-028 The read-return pipeline SHALL carry a valid bit and a requester ID per stage, sustain one read per cycle, and return reads in acceptance order.
REQ-029 Reads already in flight when CLR arrives SHALL still return their pre-clear data.
REQ-030 A write followed by a read of the same address in the next cycle SHALL return the new data; the block needs no bypass because commands are serialised.
REQ-031 A CLR pulse in the same cycle as an accepted command SHALL execute that command first; the clear begins the following cycle.

Reset
REQ-032 While RST is high: GNT_x=0, RVALID_x=0, RDATA_x=0, RAM_CE=0, RAM_WE=0, RAM_AD=0, RAM_DI=0, RAM_OCE=0, BUSY=0, last-granted pointer=B.
REQ-033 While RST is high, pipeline valid bits SHALL clear, the clear counter SHALL be 0, and the state SHALL be SERVE.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight reads and any partial clear; no RVALID follows the release.
REQ-035 With CLEAR_ON_RESET=1, the first cycle after release SHALL be in CLEAR with BUSY=1.

Structure
REQ-036 Shared package ebr_arb_pkg SHALL hold the state enum (CLEAR, SERVE), requester-ID constants (ID_A=0, ID_B=1) and the read-latency constant 3+OUTREG.
REQ-037 The round-robin decision SHALL be one sub-module, ebr_rr_arb2; the FSM, command register and return pipeline stay in the top level.

Verification
REQ-038 A-only: REQ_A write 0x1A5 to 0x0010, then read 0x0010 → RVALID_A 3 cycles after acceptance (4 with OUTREG=1) with RDATA_A=0x1A5; RVALID_B stays 0.
REQ-039 Contention: REQ_A and REQ_B held as reads for 6 cycles → grants alternate A,B,A,B,A,B; returns alternate in the same order, one per cycle.
REQ-040 Clear: preload 0x0000=0x0FF and 0x1FFF=0x155, pulse CLR → BUSY high for exactly 8192 cycles; afterwards both addresses read 0x000.
REQ-041 Reset mid-flight: accept 3 back-to-back reads, assert RST 1 cycle later → no RVALID after release; all outputs at their reset values while RST is high.
REQ-042 CLR with a read 2 cycles before it → the read returns its old value; no grant occurs during BUSY even with REQ_A held.
REQ-043 CLEAR_ON_RESET=1 → BUSY=1 from the first cycle after release for 8192 cycles, then GNT_A asserts for a pending request.

Source files
------------

// File: rtl/ebr_arb_pkg.sv
// rtl/ebr_arb_pkg.sv - shared types and constants for the EBR port arbiter
package ebr_arb_pkg;

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  // Acceptance edge to RVALID: command reg, EBR array reg, RDATA reg, plus EBR output reg.
  localparam int RD_LAT_BASE = 3;

  function automatic int rd_latency(input int outreg);
    return RD_LAT_BASE + outreg;
  endfunction

endpackage

// File: rtl/ebr_rr_arb2.sv
// rtl/ebr_rr_arb2.sv - two-way round-robin grant with last-granted pointer
module ebr_rr_arb2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic last_b_q, last_b_d;

  // Grants only ever rise with their request, so a grant is an accepted command.
  always_comb begin
    gnt_a_o  = en_i & req_a_i & (~req_b_i | last_b_q);
    gnt_b_o  = en_i & req_b_i & (~req_a_i | ~last_b_q);
    last_b_d = last_b_q;
    if (gnt_a_o) last_b_d = 1'b0;
    if (gnt_b_o) last_b_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_b_q <= 1'b1;
    else       last_b_q <= last_b_d;
  end

endmodule

// File: rtl/ebr_port_arbiter.sv
// rtl/ebr_port_arbiter.sv - two-requester front end for a single-port EBR with zero-fill
module ebr_port_arbiter
  import ebr_arb_pkg::*;
#(
  parameter int ADDR_W         = 13,
  parameter int DATA_W         = 9,
  parameter int OUTREG         = 0,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  output logic              BUSY,
  input  logic              REQ_A,
  input  logic              REQ_B,
  input  logic              WE_A,
  input  logic              WE_B,
  input  logic [ADDR_W-1:0] ADDR_A,
  input  logic [ADDR_W-1:0] ADDR_B,
  input  logic [DATA_W-1:0] WDATA_A,
  input  logic [DATA_W-1:0] WDATA_B,
  output logic              GNT_A,
  output logic              GNT_B,
  output logic              RVALID_A,
  output logic              RVALID_B,
  output logic [DATA_W-1:0] RDATA_A,
  output logic [DATA_W-1:0] RDATA_B,
  output logic              RAM_CE,
  output logic              RAM_OCE,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_AD,
  output logic [DATA_W-1:0] RAM_DI,
  input  logic [DATA_W-1:0] RAM_DO
);

  localparam int RD_LAT = rd_latency(OUTREG);
  localparam int N_STG  = RD_LAT - 1;

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              init_q;

  logic              ce_q, ce_d, we_q, we_d;
  logic [ADDR_W-1:0] ad_q, ad_d;
  logic [DATA_W-1:0] di_q, di_d;

  logic [N_STG-1:0]  rd_v_q, rd_id_q;
  logic              rvalid_a_q, rvalid_b_q;
  logic [DATA_W-1:0] rdata_a_q, rdata_b_q;

  logic              arb_en, gnt_a, gnt_b, acc_a, acc_b, acc, rd_acc;
  logic              we_sel;
  logic [ADDR_W-1:0] ad_sel;
  logic [DATA_W-1:0] di_sel;

  // A pending power-up clear also holds grants off so nothing slips in ahead of it.
  assign arb_en = ~RST & (state_q == SERVE) & ~init_q;

  ebr_rr_arb2 u_rr (
    .clk_i   (CLK),
    .rst_i   (RST),
    .en_i    (arb_en),
    .req_a_i (REQ_A),
    .req_b_i (REQ_B),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  assign acc_a  = REQ_A & gnt_a;
  assign acc_b  = REQ_B & gnt_b;
  assign acc    = acc_a | acc_b;
  assign we_sel = acc_b ? WE_B    : WE_A;
  assign ad_sel = acc_b ? ADDR_B  : ADDR_A;
  assign di_sel = acc_b ? WDATA_B : WDATA_A;
  assign rd_acc = acc & ~we_sel;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ce_d      = 1'b0;
    we_d      = 1'b0;
    ad_d      = ad_q;
    di_d      = di_q;
    unique case (state_q)
      SERVE: begin
        if (acc) begin
          ce_d = 1'b1;
          we_d = we_sel;
          ad_d = ad_sel;
          di_d = di_sel;
        end
        if (CLR || init_q) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        ce_d      = 1'b1;
        we_d      = 1'b1;
        ad_d      = clr_cnt_q;
        di_d      = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {ADDR_W{1'b1}}) state_d = SERVE;
      end
      default: state_d = SERVE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= SERVE;
      clr_cnt_q <= '0;
      init_q    <= (CLEAR_ON_RESET != 0);
      ce_q      <= 1'b0;
      we_q      <= 1'b0;
      ad_q      <= '0;
      di_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      init_q    <= 1'b0;
      ce_q      <= ce_d;
      we_q      <= we_d;
      ad_q      <= ad_d;
      di_q      <= di_d;
    end
  end

  // Stage 0 lines up with the command register; the last stage lines up with RAM_DO.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_v_q     <= '0;
      rd_id_q    <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
    end else begin
      rd_v_q     <= {rd_v_q[N_STG-2:0], rd_acc};
      rd_id_q    <= {rd_id_q[N_STG-2:0], (acc_b ? ID_B : ID_A)};
      rvalid_a_q <= rd_v_q[N_STG-1] & (rd_id_q[N_STG-1] == ID_A);
      rvalid_b_q <= rd_v_q[N_STG-1] & (rd_id_q[N_STG-1] == ID_B);
      if (rd_v_q[N_STG-1] && rd_id_q[N_STG-1] == ID_A) rdata_a_q <= RAM_DO;
      if (rd_v_q[N_STG-1] && rd_id_q[N_STG-1] == ID_B) rdata_b_q <= RAM_DO;
    end
  end

  assign GNT_A    = gnt_a;
  assign GNT_B    = gnt_b;
  assign BUSY     = (state_q == CLEAR);
  assign RVALID_A = rvalid_a_q;
  assign RVALID_B = rvalid_b_q;
  assign RDATA_A  = rdata_a_q;
  assign RDATA_B  = rdata_b_q;
  assign RAM_CE   = ce_q;
  assign RAM_WE   = we_q;
  assign RAM_AD   = ad_q;
  assign RAM_DI   = di_q;
  assign RAM_OCE  = ~RST;

endmodule

// File: tb/tb_ebr_port_arbiter.sv
// tb/tb_ebr_port_arbiter.sv - scoreboard bench for ebr_port_arbiter with behavioural EBR models
module tb_ebr_port_arbiter;

  typedef struct {
    logic [8:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // DUT 1: OUTREG=0, CLEAR_ON_RESET=0
  logic        rst = 1'b1, clr = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
  logic [12:0] addr_a = '0, addr_b = '0;
  logic [8:0]  wdata_a = '0, wdata_b = '0;
  logic        busy, gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [8:0]  rdata_a, rdata_b;
  logic        ram_ce, ram_oce, ram_we;
  logic [12:0] ram_ad;
  logic [8:0]  ram_di, ram_do;

  ebr_port_arbiter #(.ADDR_W(13), .DATA_W(9), .OUTREG(0), .CLEAR_ON_RESET(0)) u_dut (
    .CLK(clk), .RST(rst), .CLR(clr), .BUSY(busy),
    .REQ_A(req_a), .REQ_B(req_b), .WE_A(we_a), .WE_B(we_b),
    .ADDR_A(addr_a), .ADDR_B(addr_b), .WDATA_A(wdata_a), .WDATA_B(wdata_b),
    .GNT_A(gnt_a), .GNT_B(gnt_b), .RVALID_A(rvalid_a), .RVALID_B(rvalid_b),
    .RDATA_A(rdata_a), .RDATA_B(rdata_b),
    .RAM_CE(ram_ce), .RAM_OCE(ram_oce), .RAM_WE(ram_we),
    .RAM_AD(ram_ad), .RAM_DI(ram_di), .RAM_DO(ram_do)
  );

  logic [8:0] mem1 [8192];
  logic [8:0] dout1;
  always @(posedge clk) if (ram_ce) begin
    if (ram_we) mem1[ram_ad] <= ram_di;
    else        dout1 <= mem1[ram_ad];
  end
  assign ram_do = dout1;

  // DUT 2: OUTREG=1, CLEAR_ON_RESET=1, port B and CLR idle
  logic        rst2 = 1'b1;
  logic        req_a2 = 1'b0, we_a2 = 1'b0;
  logic [12:0] addr_a2 = '0;
  logic [8:0]  wdata_a2 = '0;
  logic        busy2, gnt_a2, gnt_b2, rvalid_a2, rvalid_b2;
  logic [8:0]  rdata_a2, rdata_b2;
  logic        ram_ce2, ram_oce2, ram_we2;
  logic [12:0] ram_ad2;
  logic [8:0]  ram_di2, ram_do2;

  ebr_port_arbiter #(.ADDR_W(13), .DATA_W(9), .OUTREG(1), .CLEAR_ON_RESET(1)) u_dut2 (
    .CLK(clk), .RST(rst2), .CLR(1'b0), .BUSY(busy2),
    .REQ_A(req_a2), .REQ_B(1'b0), .WE_A(we_a2), .WE_B(1'b0),
    .ADDR_A(addr_a2), .ADDR_B(13'h0), .WDATA_A(wdata_a2), .WDATA_B(9'h0),
    .GNT_A(gnt_a2), .GNT_B(gnt_b2), .RVALID_A(rvalid_a2), .RVALID_B(rvalid_b2),
    .RDATA_A(rdata_a2), .RDATA_B(rdata_b2),
    .RAM_CE(ram_ce2), .RAM_OCE(ram_oce2), .RAM_WE(ram_we2),
    .RAM_AD(ram_ad2), .RAM_DI(ram_di2), .RAM_DO(ram_do2)
  );

  logic [8:0] mem2 [8192];
  logic [8:0] dout2_r, dout2_o;
  always @(posedge clk) begin
    if (ram_ce2) begin
      if (ram_we2) mem2[ram_ad2] <= ram_di2;
      else         dout2_r <= mem2[ram_ad2];
    end
    if (ram_oce2) dout2_o <= dout2_r;
  end
  assign ram_do2 = dout2_o;

  // Reference contents and expected-return queues
  logic [8:0] shadow1 [8192];
  logic [8:0] shadow2 [8192];
  exp_t exp_a[$], exp_b[$], exp_a2[$];

  initial begin
    for (int i = 0; i < 8192; i++) begin
      shadow1[i] = '0;
      shadow2[i] = '0;
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst) begin
      exp_a.delete();
      exp_b.delete();
    end else begin
      if (rvalid_a) begin
        if (exp_a.size() == 0) check_eq("rv_a_unexpected", 1, 0);
        else begin
          e = exp_a.pop_front();
          check_eq("rdata_a", {23'd0, rdata_a}, {23'd0, e.data});
          check_eq("lat_a", cyc, e.cyc);
        end
      end
      if (rvalid_b) begin
        if (exp_b.size() == 0) check_eq("rv_b_unexpected", 1, 0);
        else begin
          e = exp_b.pop_front();
          check_eq("rdata_b", {23'd0, rdata_b}, {23'd0, e.data});
          check_eq("lat_b", cyc, e.cyc);
        end
      end
      if (req_a && req_b) check_eq("gnt_onehot", {30'd0, gnt_a, gnt_b} & (gnt_a ? 32'h1 : 32'h0), 0);
      if (busy) check_eq("gnt_in_busy", {30'd0, gnt_a, gnt_b}, 0);
      if (req_a && gnt_a) begin
        if (we_a) shadow1[addr_a] = wdata_a;
        else exp_a.push_back('{shadow1[addr_a], cyc + 3});
      end
      if (req_b && gnt_b) begin
        if (we_b) shadow1[addr_b] = wdata_b;
        else exp_b.push_back('{shadow1[addr_b], cyc + 3});
      end
      if (clr) for (int i = 0; i < 8192; i++) shadow1[i] = '0;
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst2) exp_a2.delete();
    else begin
      if (rvalid_a2) begin
        if (exp_a2.size() == 0) check_eq("rv_a2_unexpected", 1, 0);
        else begin
          e = exp_a2.pop_front();
          check_eq("rdata_a2", {23'd0, rdata_a2}, {23'd0, e.data});
          check_eq("lat_a2", cyc, e.cyc);
        end
      end
      if (rvalid_b2 || gnt_b2) check_eq("port_b2_idle", 1, 0);
      if (busy2) check_eq("gnt_in_busy2", {31'd0, gnt_a2}, 0);
      if (req_a2 && gnt_a2) begin
        if (we_a2) shadow2[addr_a2] = wdata_a2;
        else exp_a2.push_back('{shadow2[addr_a2], cyc + 4});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd_a(input logic we, input logic [12:0] a, input logic [8:0] d);
    int n = 0;
    req_a = 1'b1; we_a = we; addr_a = a; wdata_a = d;
    @(negedge clk);
    while (!gnt_a && n < 20000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20000) check_eq("cmd_a_timeout", 1, 0);
    step();
    req_a = 1'b0;
  endtask

  task automatic cmd_b(input logic we, input logic [12:0] a, input logic [8:0] d);
    int n = 0;
    req_b = 1'b1; we_b = we; addr_b = a; wdata_b = d;
    @(negedge clk);
    while (!gnt_b && n < 20000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20000) check_eq("cmd_b_timeout", 1, 0);
    step();
    req_b = 1'b0;
  endtask

  task automatic cmd_a2(input logic we, input logic [12:0] a, input logic [8:0] d);
    int n = 0;
    req_a2 = 1'b1; we_a2 = we; addr_a2 = a; wdata_a2 = d;
    @(negedge clk);
    while (!gnt_a2 && n < 20000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20000) check_eq("cmd_a2_timeout", 1, 0);
    step();
    req_a2 = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_ctl"}, {24'd0, gnt_a, gnt_b, rvalid_a, rvalid_b, ram_ce, ram_we, ram_oce, busy}, 0);
    check_eq({tag, "_rdata"}, {14'd0, rdata_a, rdata_b}, 0);
    check_eq({tag, "_ram_bus"}, {10'd0, ram_ad, ram_di}, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int w;
    int rv_cnt;

    // Reset with requests held: grants must stay low
    req_a = 1'b1; req_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs("reset");
    check_eq("reset_busy2", {31'd0, busy2 | gnt_a2}, 0);
    req_a = 1'b0; req_b = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("oce_after_release", {31'd0, ram_oce}, 1);
    step();

    // A-only write then read, with RAM bus presentation
    cmd_a(1'b1, 13'h0010, 9'h1A5);
    check_eq("ram_bus_wr", {8'd0, ram_ce, ram_we, ram_ad, ram_di}, {8'd0, 1'b1, 1'b1, 13'h0010, 9'h1A5});
    cmd_a(1'b0, 13'h0010, 9'h000);
    check_eq("ram_bus_rd", {16'd0, ram_ce, ram_we, ram_ad}, {16'd0, 1'b1, 1'b0, 13'h0010});
    step();
    check_eq("ram_ce_idle", {31'd0, ram_ce}, 0);
    repeat (4) step();

    // Contention: last grant to B, so A wins first
    cmd_a(1'b1, 13'h0020, 9'h0AA);
    cmd_b(1'b1, 13'h0021, 9'h155);
    req_a = 1'b1; we_a = 1'b0; addr_a = 13'h0020;
    req_b = 1'b1; we_b = 1'b0; addr_b = 13'h0021;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("contend_gnt", {30'd0, gnt_a, gnt_b}, (i % 2 == 0) ? 32'h2 : 32'h1);
      step();
    end
    req_a = 1'b0; req_b = 1'b0;
    repeat (6) step();

    // Clear with a read two cycles ahead of CLR and a request held through BUSY
    cmd_a(1'b1, 13'h0000, 9'h0FF);
    cmd_a(1'b1, 13'h1FFF, 9'h155);
    cmd_a(1'b0, 13'h1FFF, 9'h000);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    fork
      begin
        @(negedge clk);
        w = 0;
        while (!busy && w < 10) begin
          w++;
          @(negedge clk);
        end
        n = 0;
        while (busy && n < 9000) begin
          n++;
          @(negedge clk);
        end
        check_eq("busy_len", n, 8192);
      end
      cmd_a(1'b0, 13'h0000, 9'h000);
    join
    cmd_a(1'b0, 13'h1FFF, 9'h000);
    repeat (6) step();

    // Reset mid-flight after three back-to-back reads
    req_a = 1'b1; we_a = 1'b0; addr_a = 13'h0021;
    repeat (3) step();
    req_a = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    check_reset_outs("midrst");
    repeat (2) step();
    rst = 1'b0;
    rv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rvalid_a || rvalid_b) rv_cnt++;
    end
    check_eq("rv_after_reset", rv_cnt, 0);

    // Clear-on-reset instance with OUTREG: request pending across the fill
    req_a2 = 1'b1; we_a2 = 1'b0; addr_a2 = 13'h0005;
    @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    check_eq("cor_busy_first", {31'd0, busy2}, 1);
    n = 0;
    while (busy2 && n < 9000) begin
      n++;
      @(negedge clk);
    end
    check_eq("cor_busy_len", n, 8192);
    check_eq("cor_gnt_after", {31'd0, gnt_a2}, 1);
    step();
    req_a2 = 1'b0;
    cmd_a2(1'b1, 13'h0005, 9'h0C3);
    cmd_a2(1'b0, 13'h0005, 9'h000);
    repeat (8) step();

    check_eq("sb_empty", exp_a.size() + exp_b.size() + exp_a2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
